// File: rtl/m68k_bus_target_pkg.sv
// m68k_bus_target shared package: state encoding, register and sync constants.
// Ports: none (types and constants only).
package m68k_bus_target_pkg;

   localparam logic [2:0] DOORBELL_IDX = 3'd7;
   localparam int         NUM_REGS     = 8;
   localparam int         SYNC_STAGES  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STROBE,
      S_WAIT,
      S_ACK,
      S_RELEASE
   } state_t;

endpackage

// File: rtl/m68k_bus_target_if.sv
// 68000 bus signals seen by the register target.
// master drives strobes/address/data in; slave drives D_OUT, D_OE, DTACK_OE.
interface m68k_bus_target_if;

   logic        nAS;
   logic        nUDS;
   logic        nLDS;
   logic        RnW;
   logic [23:1] A_IN;
   logic [15:0] D_IN;
   logic        self_cycle;
   logic [15:0] D_OUT;
   logic        D_OE;
   logic        DTACK_OE;

   modport master (
      output nAS, nUDS, nLDS, RnW, A_IN, D_IN, self_cycle,
      input  D_OUT, D_OE, DTACK_OE
   );

   modport slave (
      input  nAS, nUDS, nLDS, RnW, A_IN, D_IN, self_cycle,
      output D_OUT, D_OE, DTACK_OE
   );

endinterface

// File: rtl/m68k_bus_target_bus_sync.sv
// Parameterised-width multi-flop synchronizer for raw bus inputs.
// Ports: sys_clk, sys_rst (async, high), d (raw), q (synchronized).
module bus_sync
   import m68k_bus_target_pkg::*;
#(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   (* async_reg = "true" *) logic [WIDTH-1:0] stg [SYNC_STAGES];

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= RST_VAL;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 asynchronous-bus responder for an 8-word register bank with doorbell.
// Ports: sys_clk/sys_rst, bus (slave modport), int_* Pi-side port, doorbell.
module m68k_bus_target
   import m68k_bus_target_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR   = 24'hE90000,
   parameter int          WAIT_STATES = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   m68k_bus_target_if.slave bus,
   input  logic [2:0]       int_addr,
   input  logic [15:0]      int_wdata,
   input  logic             int_we,
   output logic [15:0]      int_rdata,
   output logic             doorbell,
   input  logic             doorbell_clr
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic        nas_s, nuds_s, nlds_s, rnw_s;
   logic [23:1] a_s;
   logic [15:0] d_s;

   // Strobes idle high, so their synchronizer resets to all-ones.
   bus_sync #(.WIDTH(4), .RST_VAL(4'hF)) u_sync_strb (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .d       ({bus.nAS, bus.nUDS, bus.nLDS, bus.RnW}),
      .q       ({nas_s, nuds_s, nlds_s, rnw_s})
   );

   bus_sync #(.WIDTH(23)) u_sync_addr (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .d       (bus.A_IN),
      .q       (a_s)
   );

   bus_sync #(.WIDTH(16)) u_sync_data (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .d       (bus.D_IN),
      .q       (d_s)
   );

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [2:0]  idx_q;
   logic        rnw_q;
   logic [15:0] dout_q;
   logic [15:0] regs [NUM_REGS];
   logic        hit, abort, bus_we;

   assign hit   = !nas_s && (a_s[23:4] == BASE_ADDR[23:4]) && !bus.self_cycle;
   assign abort = nas_s || bus.self_cycle;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_IDLE: begin
            if (hit) state_n = S_STROBE;
         end
         S_STROBE: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (!nuds_s || !nlds_s) begin
               cnt_n   = WS;
               state_n = (WS == 4'd0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            // ACK is entered exactly WS cycles after leaving STROBE.
            if (abort)           state_n = S_IDLE;
            else if (cnt <= 4'd1) state_n = S_ACK;
            else                 cnt_n   = cnt - 4'd1;
         end
         S_ACK: begin
            state_n = S_RELEASE;
         end
         S_RELEASE: begin
            if (nas_s) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         idx_q  <= '0;
         rnw_q  <= 1'b0;
         dout_q <= '0;
      end else begin
         if (state == S_IDLE && hit) begin
            idx_q <= a_s[3:1];
            rnw_q <= rnw_s;
         end
         // Captured on ACK entry so read data holds until release.
         if (state_n == S_ACK && rnw_q) dout_q <= regs[idx_q];
      end
   end

   assign bus_we = (state == S_ACK) && !rnw_q;

   // Bus lanes take priority; internal write fills the untouched lanes.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus_we && idx_q == 3'(i) && !nuds_s)
               regs[i][15:8] <= d_s[15:8];
            else if (int_we && int_addr == 3'(i))
               regs[i][15:8] <= int_wdata[15:8];
            if (bus_we && idx_q == 3'(i) && !nlds_s)
               regs[i][7:0] <= d_s[7:0];
            else if (int_we && int_addr == 3'(i))
               regs[i][7:0] <= int_wdata[7:0];
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         doorbell  <= 1'b0;
         int_rdata <= '0;
      end else begin
         if (bus_we && idx_q == DOORBELL_IDX) doorbell <= 1'b1;
         else if (doorbell_clr)               doorbell <= 1'b0;
         int_rdata <= regs[int_addr];
      end
   end

   assign bus.DTACK_OE = (state == S_ACK && !rnw_q) || (state == S_RELEASE);
   assign bus.D_OE     = rnw_q && (state == S_ACK || state == S_RELEASE);
   assign bus.D_OUT    = dout_q;

endmodule
